// File: rtl/iter_mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iter_mul_ctrl
//  Description : Iterative shift-and-add 32x32 multiplier controller; stalls
//                the pipeline while RUN is active and pulses done_o once the
//                low 32 product bits are ready. Optional early termination
//                when macro ITER_MUL_EARLY_TERM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_mul_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [5:0]  run_cycles_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [5:0] c_MAX_CNT = 6'd32;

    logic [1:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;
    logic [5:0]  r_run_cycles;

    logic [31:0] w_acc_nxt;
    logic [31:0] w_a_nxt;
    logic [31:0] w_b_nxt;
    logic [5:0]  w_cnt_nxt;
    logic        w_last;

    // One shift-and-add step; the accumulator wraps, so only the low word survives.
    always_comb begin
        w_acc_nxt = r_acc + (r_b[0] ? r_a : 32'd0);
        w_a_nxt   = r_a << 1;
        w_b_nxt   = r_b >> 1;
        w_cnt_nxt = r_cnt + 6'd1;
`ifdef ITER_MUL_EARLY_TERM_EN
        w_last    = (w_cnt_nxt == c_MAX_CNT) || (w_b_nxt == 32'd0);
`else
        w_last    = (w_cnt_nxt == c_MAX_CNT);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_ST_IDLE;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_acc        <= 32'd0;
            r_cnt        <= 6'd0;
            r_result     <= 32'd0;
            r_run_cycles <= 6'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_a     <= src1_i;
                        r_b     <= src2_i;
                        r_acc   <= 32'd0;
                        r_cnt   <= 6'd0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_result     <= w_acc_nxt;
                        r_run_cycles <= w_cnt_nxt;
                        r_state      <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Stall is raised in the accepting IDLE cycle so the PC never moves past the mul.
    assign stall_o      = ((r_state == c_ST_IDLE) && start_i) || (r_state == c_ST_RUN);
    assign busy_o       = (r_state != c_ST_IDLE);
    assign done_o       = (r_state == c_ST_DONE);
    assign result_o     = r_result;
    assign run_cycles_o = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_iter_mul_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_iter_mul_ctrl
//  Description : Self-checking bench for iter_mul_ctrl against an arithmetic
//                reference model (product mod 2^32, RUN cycle count from B).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [5:0]  run_cycles;

    int n_checks = 0;
    int n_errors = 0;

    iter_mul_ctrl u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src1_i       (src1),
        .src2_i       (src2),
        .stall_o      (stall),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .run_cycles_o (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    // Number of RUN cycles the multiplier should spend for multiplier value b.
    function automatic int model_cycles(input logic [31:0] b);
`ifdef ITER_MUL_EARLY_TERM_EN
        int top;
        top = 0;
        for (int i = 0; i < 32; i++) if (b[i]) top = i;
        return top + 1;
`else
        return 32;
`endif
    endfunction

    // Inputs are applied at the falling edge, outputs sampled 1 ns later.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input string tag);
        logic [31:0] exp_res;
        int          exp_run;
        int          done_cyc;
        exp_res  = model_product(a, b);
        exp_run  = model_cycles(b);
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1; src1 = a; src2 = b;
        #1;
        n_checks++;
        if ({stall, busy, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL %s accept: stall/busy/done=%b required 100", tag, {stall, busy, done});
        end
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            src1 = $urandom; src2 = $urandom;
            #1;
            if (done === 1'b1) begin
                done_cyc = c;
                n_checks++;
                if ({stall, busy} !== 2'b01) begin
                    n_errors++;
                    $display("FAIL %s done_flags: stall/busy=%b required 01", tag, {stall, busy});
                end
                n_checks++;
                if (result !== exp_res) begin
                    n_errors++;
                    $display("FAIL %s result: got %h required %h", tag, result, exp_res);
                end
                n_checks++;
                if (run_cycles !== 6'(exp_run)) begin
                    n_errors++;
                    $display("FAIL %s run_cycles: got %0d required %0d", tag, run_cycles, exp_run);
                end
            end else begin
                n_checks++;
                if ({stall, busy} !== 2'b11) begin
                    n_errors++;
                    $display("FAIL %s run_flags cycle %0d: stall/busy=%b required 11", tag, c, {stall, busy});
                end
            end
        end
        n_checks++;
        if (done_cyc != exp_run + 1) begin
            n_errors++;
            $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, exp_run + 1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; src1 = $urandom; src2 = $urandom;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if ({stall, busy, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: stall/busy/done=%b required 000", {stall, busy, done});
        end
        n_checks++;
        if (result !== 32'd0 || run_cycles !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_regs: result=%h run_cycles=%0d required 0/0", result, run_cycles);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0; src1 = $urandom; src2 = $urandom;
            #1;
            n_checks++;
            if ({stall, busy, done} !== 3'b000 || result !== 32'd0) begin
                n_errors++;
                $display("FAIL idle cycle %0d: flags=%b result=%h required 000/0", i, {stall, busy, done}, result);
            end
        end
    endtask

    task automatic test_basic();
        run_op(32'd3, 32'd5, 1'b0, "mul_3x5");
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mul_neg1x2");
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "mul_overflow");
        run_op(32'd7, 32'd1, 1'b0, "mul_7x1");
        run_op(32'h1234_5678, 32'd0, 1'b0, "mul_by_zero");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h8000_0001;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (c == 10);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            n_checks++;
            if ({stall, busy, done} !== 3'b000 || result !== 32'd0) begin
                n_errors++;
                $display("FAIL abort cycle %0d: flags=%b result=%h required 000/0", c, {stall, busy, done}, result);
            end
        end
        run_op(32'd6, 32'd7, 1'b0, "mul_after_abort");
        // reset takes priority over a simultaneous start request
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if ({busy, result} !== {1'b0, 32'd0}) begin
            n_errors++;
            $display("FAIL rst_priority: busy=%b result=%h required 0/0", busy, result);
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'd4, 32'd4, 1'b1, "b2b_first");
        run_op(32'd4, 32'd4, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 10; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 3 == 1) b = b >> $urandom_range(31, 16);
            run_op(a, b, 1'b0, "rand");
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                start = 1'b0; src1 = $urandom; src2 = $urandom;
                #1;
                n_checks++;
                if ({busy, done} !== 2'b00 || result !== model_product(a, b)) begin
                    n_errors++;
                    $display("FAIL rand_hold: busy/done=%b result=%h required 00/%h", {busy, done}, result, model_product(a, b));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src1 = 32'd0; src2 = 32'd0;
        test_reset();
        test_idle();
        test_basic();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_mul_ctrl.md
ITER_MUL_CTRL -- requirements
Module: iter_mul_ctrl

Interface
REQ-001 SHALL provide clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide start_i  input  1  multiply request from decode (ALU control = mul), level, sampled only in IDLE.
REQ-004 SHALL provide src1_i  input  32  multiplicand (rs).
REQ-005 SHALL provide src2_i  input  32  multiplier (rt).
REQ-006 SHALL provide stall_o  output  1  holds PC and register write while the multiply is in progress.
REQ-007 SHALL provide busy_o  output  1  high when state is not IDLE.
REQ-008 SHALL provide done_o  output  1  one-cycle pulse; result_o valid for write-back.
REQ-009 SHALL provide result_o  output  32  low 32 bits of the product, registered.
REQ-010 SHALL provide run_cycles_o  output  6  RUN cycles used by the last completed operation.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 SHALL leave IDLE only when start_i=1: latch A=src1_i, B=src2_i, acc=0, cnt=0, then go to RUN.
REQ-013 SHALL, in each RUN cycle: acc+=A if B[0]=1 (mod 2^32), A<<=1, B>>=1 (logical), cnt+=1.
REQ-014 SHALL go RUN->DONE at the end of the cycle in which cnt reaches 32 (32 RUN cycles) when REQ-030 is disabled.
REQ-015 SHALL, on entering DONE, load result_o=acc and run_cycles_o=cnt; DONE lasts exactly one cycle, then IDLE.
REQ-016 SHALL drive stall_o = (IDLE and start_i) or RUN, combinationally; stall_o=0 in DONE so the PC advances and write-back occurs.
REQ-017 SHALL drive done_o=1 only in DONE.
REQ-018 SHALL ignore start_i in RUN and DONE; a start_i high in the cycle after DONE begins a new operation (back-to-back allowed).
REQ-019 SHALL produce identical low 32 bits for signed and unsigned operands; overflow is discarded (wrap-around).
REQ-020 SHALL hold result_o and run_cycles_o stable from DONE until the next DONE.
REQ-021 SHALL have latency: start accepted in cycle 0, RUN in cycles 1..32, done_o in cycle 33 (default build).

Reset
REQ-022 SHALL, when rst_i=1 at a clock edge, force state=IDLE, acc=0, A=0, B=0, cnt=0, result_o=0, run_cycles_o=0.
REQ-023 SHALL drive stall_o=0, busy_o=0, done_o=0 in the cycle after reset, regardless of start_i during reset.
REQ-024 SHALL abort an operation in progress on reset mid-RUN or in DONE with no done_o pulse; rst_i has priority over start_i.

Configuration
REQ-030 SHALL, when macro ITER_MUL_EARLY_TERM_EN is defined, also go RUN->DONE at the end of any RUN cycle whose shifted B value is zero (minimum 1 RUN cycle).
REQ-031 SHALL, when ITER_MUL_EARLY_TERM_EN is undefined, always use exactly 32 RUN cycles; results are identical in both builds.

Verification
REQ-040 SHALL cover: reset, start_i=1, src1=3, src2=5 -> stall_o high cycles 0..32, done_o in cycle 33, result_o=0x0000000F, run_cycles_o=32.
REQ-041 SHALL cover: src1=0xFFFFFFFF, src2=0x00000002 -> result_o=0xFFFFFFFE; src1=0x00010000, src2=0x00010000 -> result_o=0x00000000.
REQ-042 SHALL cover: rst_i=1 in RUN cycle 10 -> next cycle busy_o=0, stall_o=0, result_o=0, no done_o; a new start of 6*7 then yields result_o=0x0000002A.
REQ-043 SHALL cover: start_i held high through DONE (4*4) -> single done_o; next op starts in cycle 34, done_o in cycle 67, result_o=0x10.
REQ-044 SHALL cover: ITER_MUL_EARLY_TERM_EN defined, src1=7, src2=1 -> done_o in cycle 2, run_cycles_o=1, result_o=7; undefined -> done_o in cycle 33, run_cycles_o=32.
REQ-045 SHALL cover: start_i=0 for 20 cycles after reset -> stall_o, busy_o, done_o remain 0 and result_o stays 0.
